dmem_lane_arbiter: RTL and testbench
====================================

Name: dmem_lane_arbiter

Overview:
- Shares the single-port data memory between the two memory lanes of the dual-issue pipeline.
- Lane 0 is always the older instruction of an issue bundle.
- Requests are serialised in program order, so a lane-0 store followed by a lane-1 load to the same word returns the new data.
- Each request is checked for misalignment and range, and its response is returned to the originating lane one cycle after issue.

Parameters:
- DEPTH, 1024: data memory size in 32-bit words.
- ADDR_W, $clog2(DEPTH): width of the word index driven to memory.
- CNT_W, 16: width of the saturating conflict counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- flush_i  in  1  pipeline flush; kills pending and in-flight work
- l0_req_valid_i  in  1  lane 0 request valid
- l0_req_ready_o  out  1  lane 0 request accepted this cycle
- l0_addr_i  in  32  lane 0 byte address
- l0_wdata_i  in  32  lane 0 store data
- l0_we_i  in  1  lane 0 store (1) / load (0)
- l0_rd_i  in  5  lane 0 destination register
- l1_req_valid_i, l1_req_ready_o, l1_addr_i, l1_wdata_i, l1_we_i, l1_rd_i: same as lane 0, for lane 1
- l0_rsp_valid_o  out  1  lane 0 response valid (one-cycle pulse)
- l0_rsp_data_o  out  32  load data; 0 for stores and faults
- l0_rsp_rd_o  out  5  destination register of the response
- l0_rsp_fault_o  out  1  misaligned or out-of-range access
- l1_rsp_valid_o, l1_rsp_data_o, l1_rsp_rd_o, l1_rsp_fault_o: same as lane 0, for lane 1
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  word index (byte address [ADDR_W+1:2])
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  synchronous read data, valid the cycle after mem_en_o
- conflict_cnt_o  out  CNT_W  saturating count of lane-1 conflict stall cycles

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; counter 0.
- Handshake: a request transfers when valid and ready are both high. Ready is combinational from state, valids and flush_i. Upstream holds the request stable until it is accepted.
- Fault: bit 1 or bit 0 of the address set, or word index >= DEPTH, sets fault=1. A faulting request is still accepted, issues no memory access (mem_en_o=0), and responds next cycle with fault=1 and data 0.
- FSM state IDLE:
  - l0 valid: l0_ready=1 and l0 issues this cycle. If l1 is also valid, l1_ready=0, next state SERVE1, counter +1. Otherwise stay in IDLE.
  - Only l1 valid: l1_ready=1, l1 issues, stay in IDLE.
- FSM state SERVE1:
  - l0_ready=0.
  - l1 valid: l1 issues, l1_ready=1, next state IDLE.
  - l1 not valid (withdrawn): next state IDLE, nothing issued.
- Under continuous traffic on both lanes the FSM alternates IDLE/SERVE1. Neither lane starves.
- Issue: mem_en_o=1 for a non-faulting accepted request. mem_we_o=we; address and wdata come from the issuing lane. Exactly one access per cycle at most.
- Response latency is 1 cycle:
  - A registered lane tag, rd, fault and load/store flag capture each issue.
  - Next cycle, rsp_valid pulses on the tagged lane only.
  - Load data = mem_rdata_i. Store data = 0; a store still produces a completion response.
- Flush:
  - In the flush cycle both readys are 0 and mem_en_o=0.
  - FSM returns to IDLE.
  - A response due in the following cycle is suppressed: rsp_valid=0. This includes a store already written to memory; the write is not undone.
- Reset mid-operation: pending SERVE1 and in-flight responses are discarded immediately.
- Counter: increments once per IDLE->SERVE1 transition and saturates at all-ones. It is not cleared by flush.

Decomposition:
- Shared package mem_pkg holds: lane-id typedef (LANE0/LANE1), FSM state enum (IDLE, SERVE1), request struct (addr, wdata, we, rd), and the constant RSP_LATENCY=1.
- One sub-module is natural: dmem_req_check, purely combinational, computing the fault flag and word index. It is instantiated once per lane.

Test Plan:
- Lane 0 only, store 0xDEADBEEF to 0x10, then load 0x10 -> mem_en at issue, mem_addr=4; load returns l0_rsp_data=0xDEADBEEF one cycle later; l1_rsp_valid stays 0.
- Both lanes valid same cycle: l0 stores 0x1234 to 0x20, l1 loads 0x20 -> cycle N l0_ready=1 and l1_ready=0; cycle N+1 l1 issues; l1_rsp_data=0x1234 at N+2; conflict_cnt_o=1.
- Lane 1 load from 0x22 -> l1_rsp_fault=1, data 0, no mem_en. Lane 0 load from byte 0x1000 with DEPTH=1024 -> l0_rsp_fault=1.
- flush_i asserted in the SERVE1 cycle -> l1 not issued; the lane-0 response due next cycle is suppressed; FSM returns to IDLE.
- Both lanes valid every cycle for 10 cycles -> alternating grants, 5 issues per lane; conflict_cnt_o=5. Run with CNT_W=2 to confirm saturation at 3.
- rst_n deasserted mid-SERVE1 -> all outputs 0 immediately; first request after release is served from IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the data-memory lane arbiter: lane tags, arbiter states,
// the per-lane request bundle and the fixed response latency.
package mem_pkg;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SERVE1 = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [4:0]  rd;
  } req_t;

  localparam int RSP_LATENCY = 1;

endpackage

// File: rtl/dmem_req_check.sv
// Per-lane request decode: derives the word index and flags misaligned or
// out-of-range byte addresses.
module dmem_req_check
  import mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [31:0]       addr,
  output logic              fault,
  output logic [ADDR_W-1:0] word_idx
);

  assign word_idx = addr[ADDR_W+1:2];

  // The full upper address is compared, so aliases above DEPTH fault rather than wrap.
  assign fault = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));

endmodule

// File: rtl/dmem_lane_arbiter.sv
// Serialises the two pipeline memory lanes onto one single-port data memory
// in program order (lane 0 first) and routes each response back to its lane.
module dmem_lane_arbiter
  import mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              l0_req_valid_i,
  output logic              l0_req_ready_o,
  input  logic [31:0]       l0_addr_i,
  input  logic [31:0]       l0_wdata_i,
  input  logic              l0_we_i,
  input  logic [4:0]        l0_rd_i,
  input  logic              l1_req_valid_i,
  output logic              l1_req_ready_o,
  input  logic [31:0]       l1_addr_i,
  input  logic [31:0]       l1_wdata_i,
  input  logic              l1_we_i,
  input  logic [4:0]        l1_rd_i,
  output logic              l0_rsp_valid_o,
  output logic [31:0]       l0_rsp_data_o,
  output logic [4:0]        l0_rsp_rd_o,
  output logic              l0_rsp_fault_o,
  output logic              l1_rsp_valid_o,
  output logic [31:0]       l1_rsp_data_o,
  output logic [4:0]        l1_rsp_rd_o,
  output logic              l1_rsp_fault_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  req_t              l0_req, l1_req;
  logic              l0_fault, l1_fault;
  logic [ADDR_W-1:0] l0_idx, l1_idx;

  assign l0_req = '{addr: l0_addr_i, wdata: l0_wdata_i, we: l0_we_i, rd: l0_rd_i};
  assign l1_req = '{addr: l1_addr_i, wdata: l1_wdata_i, we: l1_we_i, rd: l1_rd_i};

  dmem_req_check #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_l0_check (
    .addr     (l0_req.addr),
    .fault    (l0_fault),
    .word_idx (l0_idx)
  );

  dmem_req_check #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_l1_check (
    .addr     (l1_req.addr),
    .fault    (l1_fault),
    .word_idx (l1_idx)
  );

  state_e state_q, state_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // SERVE1 lasts exactly one cycle whether or not lane 1 is still asking.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = IDLE;
    if (!flush_i && state_q == IDLE && l0_req_valid_i && l1_req_valid_i) state_d = SERVE1;
  end

  always_comb begin
    l0_req_ready_o = 1'b0;
    l1_req_ready_o = 1'b0;
    // NOTE: readys are gated with rst_n so outputs are quiet for the whole reset window.
    if (rst_n && !flush_i) begin
      unique case (state_q)
        IDLE: begin
          l0_req_ready_o = l0_req_valid_i;
          l1_req_ready_o = l1_req_valid_i && !l0_req_valid_i;
        end
        SERVE1: l1_req_ready_o = l1_req_valid_i;
        default: ;
      endcase
    end
  end

  logic  issue, iss_fault, iss_we;
  lane_e iss_lane;
  logic [4:0] iss_rd;

  assign issue     = l0_req_ready_o || l1_req_ready_o;
  assign iss_lane  = l1_req_ready_o ? LANE1 : LANE0;
  assign iss_fault = (iss_lane == LANE1) ? l1_fault  : l0_fault;
  assign iss_we    = (iss_lane == LANE1) ? l1_req.we : l0_req.we;
  assign iss_rd    = (iss_lane == LANE1) ? l1_req.rd : l0_req.rd;

  assign mem_en_o    = issue && !iss_fault;
  assign mem_we_o    = mem_en_o && iss_we;
  assign mem_addr_o  = !mem_en_o ? '0 : (iss_lane == LANE1) ? l1_idx : l0_idx;
  assign mem_wdata_o = !mem_en_o ? '0 : (iss_lane == LANE1) ? l1_req.wdata : l0_req.wdata;

  // Response tag pipeline; nothing issues during a flush, so it drains on its own.
  logic [RSP_LATENCY-1:0] rsp_pend_q;
  lane_e                  rsp_lane_q;
  logic [4:0]             rsp_rd_q;
  logic                   rsp_fault_q, rsp_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend_q  <= '0;
      rsp_lane_q  <= LANE0;
      rsp_rd_q    <= '0;
      rsp_fault_q <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      rsp_pend_q <= {RSP_LATENCY{issue}};
      if (issue) begin
        rsp_lane_q  <= iss_lane;
        rsp_rd_q    <= iss_rd;
        rsp_fault_q <= iss_fault;
        rsp_we_q    <= iss_we;
      end
    end
  end

  logic        rsp_live;
  logic [31:0] rsp_data;

  assign rsp_live = rsp_pend_q[RSP_LATENCY-1] && !flush_i;
  assign rsp_data = (rsp_fault_q || rsp_we_q) ? 32'd0 : mem_rdata_i;

  assign l0_rsp_valid_o = rsp_live && rsp_lane_q == LANE0;
  assign l1_rsp_valid_o = rsp_live && rsp_lane_q == LANE1;
  assign l0_rsp_data_o  = l0_rsp_valid_o ? rsp_data : 32'd0;
  assign l1_rsp_data_o  = l1_rsp_valid_o ? rsp_data : 32'd0;
  assign l0_rsp_rd_o    = l0_rsp_valid_o ? rsp_rd_q : 5'd0;
  assign l1_rsp_rd_o    = l1_rsp_valid_o ? rsp_rd_q : 5'd0;
  assign l0_rsp_fault_o = l0_rsp_valid_o && rsp_fault_q;
  assign l1_rsp_fault_o = l1_rsp_valid_o && rsp_fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_o <= '0;
    end else if (state_q == IDLE && state_d == SERVE1 && conflict_cnt_o != '1) begin
      conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Bench for dmem_lane_arbiter: directed scenarios plus a randomized run
// against a cycle-level model of program-order arbitration and memory contents.
module tb_dmem_lane_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        l0_v = 1'b0, l1_v = 1'b0;
  logic [31:0] l0_addr = '0, l1_addr = '0, l0_wd = '0, l1_wd = '0;
  logic        l0_we = 1'b0, l1_we = 1'b0;
  logic [4:0]  l0_rd = '0, l1_rd = '0;

  logic        l0_rdy, l1_rdy, l0_rv, l1_rv, l0_rf, l1_rf;
  logic [31:0] l0_rdat, l1_rdat;
  logic [4:0]  l0_rrd, l1_rrd;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] cnt;

  logic        s_l0_rdy, s_l1_rdy, s_l0_rv, s_l1_rv, s_l0_rf, s_l1_rf;
  logic [31:0] s_l0_rdat, s_l1_rdat;
  logic [4:0]  s_l0_rrd, s_l1_rrd;
  logic        s_mem_en, s_mem_we;
  logic [9:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [1:0]  s_cnt;

  int n_pass = 0;
  int n_total = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  dmem_lane_arbiter #(.DEPTH(1024), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .l0_req_valid_i(l0_v), .l0_req_ready_o(l0_rdy), .l0_addr_i(l0_addr),
    .l0_wdata_i(l0_wd), .l0_we_i(l0_we), .l0_rd_i(l0_rd),
    .l1_req_valid_i(l1_v), .l1_req_ready_o(l1_rdy), .l1_addr_i(l1_addr),
    .l1_wdata_i(l1_wd), .l1_we_i(l1_we), .l1_rd_i(l1_rd),
    .l0_rsp_valid_o(l0_rv), .l0_rsp_data_o(l0_rdat), .l0_rsp_rd_o(l0_rrd), .l0_rsp_fault_o(l0_rf),
    .l1_rsp_valid_o(l1_rv), .l1_rsp_data_o(l1_rdat), .l1_rsp_rd_o(l1_rrd), .l1_rsp_fault_o(l1_rf),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .conflict_cnt_o(cnt)
  );

  // Narrow-counter copy sees identical traffic; only its counter is observed.
  dmem_lane_arbiter #(.DEPTH(1024), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .l0_req_valid_i(l0_v), .l0_req_ready_o(s_l0_rdy), .l0_addr_i(l0_addr),
    .l0_wdata_i(l0_wd), .l0_we_i(l0_we), .l0_rd_i(l0_rd),
    .l1_req_valid_i(l1_v), .l1_req_ready_o(s_l1_rdy), .l1_addr_i(l1_addr),
    .l1_wdata_i(l1_wd), .l1_we_i(l1_we), .l1_rd_i(l1_rd),
    .l0_rsp_valid_o(s_l0_rv), .l0_rsp_data_o(s_l0_rdat), .l0_rsp_rd_o(s_l0_rrd), .l0_rsp_fault_o(s_l0_rf),
    .l1_rsp_valid_o(s_l1_rv), .l1_rsp_data_o(s_l1_rdat), .l1_rsp_rd_o(s_l1_rrd), .l1_rsp_fault_o(s_l1_rf),
    .mem_en_o(s_mem_en), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata),
    .mem_rdata_i(mem_rdata), .conflict_cnt_o(s_cnt)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  logic [31:0] ram [0:1023];
  initial for (int i = 0; i < 1024; i++) ram[i] = init_word(i);

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    l0_v = 1'b1; l1_v = 1'b1; l0_addr = 32'h10; l1_addr = 32'h20;
    @(negedge clk);
    n_total++; if (l0_rdy !== 1'b0) $display("FAIL reset_l0_ready got=%0h exp=0", l0_rdy); else n_pass++;
    n_total++; if (l1_rdy !== 1'b0) $display("FAIL reset_l1_ready got=%0h exp=0", l1_rdy); else n_pass++;
    n_total++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en got=%0h exp=0", mem_en); else n_pass++;
    n_total++; if ({l0_rv, l1_rv} !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", {l0_rv, l1_rv}); else n_pass++;
    n_total++; if (cnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", cnt); else n_pass++;
    tick();
    rst_n = 1'b1; l0_v = 1'b0; l1_v = 1'b0;
    tick();
  endtask

  task automatic test_single_lane();
    l0_v = 1'b1; l0_addr = 32'h10; l0_wd = 32'hDEADBEEF; l0_we = 1'b1; l0_rd = 5'd3;
    @(negedge clk);
    n_total++; if (l0_rdy !== 1'b1) $display("FAIL single_st_ready got=%0h exp=1", l0_rdy); else n_pass++;
    n_total++; if ({mem_en, mem_we} !== 2'b11) $display("FAIL single_st_en_we got=%b exp=11", {mem_en, mem_we}); else n_pass++;
    n_total++; if (mem_addr !== 10'd4) $display("FAIL single_st_addr got=%0d exp=4", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL single_st_wdata got=%h exp=deadbeef", mem_wdata); else n_pass++;
    tick();
    l0_we = 1'b0; l0_wd = 32'h0; l0_rd = 5'd7;
    @(negedge clk);
    n_total++; if ({l0_rv, l0_rrd, l0_rdat} !== {1'b1, 5'd3, 32'd0}) $display("FAIL single_st_rsp got=%b/%0d/%h exp=1/3/0", l0_rv, l0_rrd, l0_rdat); else n_pass++;
    n_total++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 10'd4}) $display("FAIL single_ld_issue got=%b/%b/%0d exp=1/0/4", mem_en, mem_we, mem_addr); else n_pass++;
    tick();
    l0_v = 1'b0;
    @(negedge clk);
    n_total++; if ({l0_rv, l0_rrd} !== {1'b1, 5'd7}) $display("FAIL single_ld_rsp got=%b/%0d exp=1/7", l0_rv, l0_rrd); else n_pass++;
    n_total++; if (l0_rdat !== 32'hDEADBEEF) $display("FAIL single_ld_data got=%h exp=deadbeef", l0_rdat); else n_pass++;
    n_total++; if (l1_rv !== 1'b0) $display("FAIL single_l1_quiet got=%0h exp=0", l1_rv); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (l0_rv !== 1'b0) $display("FAIL single_rsp_pulse got=%0h exp=0", l0_rv); else n_pass++;
    tick();
  endtask

  task automatic test_conflict();
    l0_v = 1'b1; l0_addr = 32'h20; l0_wd = 32'h1234; l0_we = 1'b1; l0_rd = 5'd1;
    l1_v = 1'b1; l1_addr = 32'h20; l1_wd = 32'h0;    l1_we = 1'b0; l1_rd = 5'd2;
    @(negedge clk);
    n_total++; if ({l0_rdy, l1_rdy} !== 2'b10) $display("FAIL conflict_n_ready got=%b exp=10", {l0_rdy, l1_rdy}); else n_pass++;
    tick();
    l0_v = 1'b0; exp_cnt++;
    @(negedge clk);
    n_total++; if ({l0_rdy, l1_rdy} !== 2'b01) $display("FAIL conflict_n1_ready got=%b exp=01", {l0_rdy, l1_rdy}); else n_pass++;
    n_total++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 10'd8}) $display("FAIL conflict_n1_issue got=%b/%b/%0d exp=1/0/8", mem_en, mem_we, mem_addr); else n_pass++;
    n_total++; if ({l0_rv, l0_rrd} !== {1'b1, 5'd1}) $display("FAIL conflict_st_rsp got=%b/%0d exp=1/1", l0_rv, l0_rrd); else n_pass++;
    n_total++; if (cnt !== 16'(exp_cnt)) $display("FAIL conflict_cnt got=%0d exp=%0d", cnt, exp_cnt); else n_pass++;
    n_total++; if (s_cnt !== 2'd1) $display("FAIL conflict_sat_cnt got=%0d exp=1", s_cnt); else n_pass++;
    tick();
    l1_v = 1'b0;
    @(negedge clk);
    n_total++; if ({l1_rv, l1_rrd, l1_rdat} !== {1'b1, 5'd2, 32'h1234}) $display("FAIL conflict_ld_rsp got=%b/%0d/%h exp=1/2/1234", l1_rv, l1_rrd, l1_rdat); else n_pass++;
    n_total++; if (l0_rv !== 1'b0) $display("FAIL conflict_l0_quiet got=%0h exp=0", l0_rv); else n_pass++;
    tick();
  endtask

  task automatic test_fault();
    l1_v = 1'b1; l1_addr = 32'h22; l1_we = 1'b0; l1_rd = 5'd4;
    @(negedge clk);
    n_total++; if ({l1_rdy, mem_en} !== 2'b10) $display("FAIL fault_l1_issue got=%b exp=10", {l1_rdy, mem_en}); else n_pass++;
    tick();
    l1_v = 1'b0;
    l0_v = 1'b1; l0_addr = 32'h1000; l0_we = 1'b0; l0_rd = 5'd5;
    @(negedge clk);
    n_total++; if ({l1_rv, l1_rf, l1_rdat, l1_rrd} !== {2'b11, 32'd0, 5'd4}) $display("FAIL fault_l1_rsp got=%b/%b/%h/%0d exp=1/1/0/4", l1_rv, l1_rf, l1_rdat, l1_rrd); else n_pass++;
    n_total++; if ({l0_rdy, mem_en} !== 2'b10) $display("FAIL fault_l0_issue got=%b exp=10", {l0_rdy, mem_en}); else n_pass++;
    tick();
    l0_v = 1'b0;
    @(negedge clk);
    n_total++; if ({l0_rv, l0_rf, l0_rdat} !== {2'b11, 32'd0}) $display("FAIL fault_l0_rsp got=%b/%b/%h exp=1/1/0", l0_rv, l0_rf, l0_rdat); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    l0_v = 1'b1; l0_addr = 32'h10; l0_we = 1'b0; l0_rd = 5'd8;
    l1_v = 1'b1; l1_addr = 32'h20; l1_we = 1'b0; l1_rd = 5'd9;
    @(negedge clk);
    n_total++; if ({l0_rdy, l1_rdy} !== 2'b10) $display("FAIL flush_pre_ready got=%b exp=10", {l0_rdy, l1_rdy}); else n_pass++;
    tick();
    l0_v = 1'b0; flush = 1'b1; exp_cnt++;
    @(negedge clk);
    n_total++; if ({l0_rdy, l1_rdy, mem_en} !== 3'b000) $display("FAIL flush_cycle_quiet got=%b exp=000", {l0_rdy, l1_rdy, mem_en}); else n_pass++;
    n_total++; if (l0_rv !== 1'b0) $display("FAIL flush_rsp_suppressed got=%0h exp=0", l0_rv); else n_pass++;
    tick();
    flush = 1'b0;
    l0_v = 1'b1; l0_rd = 5'd10;
    @(negedge clk);
    n_total++; if ({l0_rdy, l1_rdy} !== 2'b10) $display("FAIL flush_back_idle got=%b exp=10", {l0_rdy, l1_rdy}); else n_pass++;
    n_total++; if ({l0_rv, l1_rv} !== 2'b00) $display("FAIL flush_no_late_rsp got=%b exp=00", {l0_rv, l1_rv}); else n_pass++;
    tick();
    l0_v = 1'b0; exp_cnt++;
    @(negedge clk);
    n_total++; if (l1_rdy !== 1'b1) $display("FAIL flush_l1_served got=%0h exp=1", l1_rdy); else n_pass++;
    n_total++; if ({l0_rv, l0_rdat} !== {1'b1, 32'hDEADBEEF}) $display("FAIL flush_l0_rsp got=%b/%h exp=1/deadbeef", l0_rv, l0_rdat); else n_pass++;
    n_total++; if (cnt !== 16'(exp_cnt)) $display("FAIL flush_cnt_kept got=%0d exp=%0d", cnt, exp_cnt); else n_pass++;
    tick();
    l1_v = 1'b0;
    @(negedge clk);
    n_total++; if ({l1_rv, l1_rdat} !== {1'b1, 32'h1234}) $display("FAIL flush_l1_rsp got=%b/%h exp=1/1234", l1_rv, l1_rdat); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int g0 = 0, g1 = 0;
    int bad = 0;
    l0_v = 1'b1; l0_addr = 32'h10; l0_we = 1'b0;
    l1_v = 1'b1; l1_addr = 32'h20; l1_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ({l0_rdy, l1_rdy} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) bad++;
      if (l0_rdy === 1'b1) g0++;
      if (l1_rdy === 1'b1) g1++;
      tick();
    end
    l0_v = 1'b0; l1_v = 1'b0;
    exp_cnt += 5;
    @(negedge clk);
    n_total++; if (bad !== 0) $display("FAIL b2b_alternation got=%0d exp=0 wrong grant cycles", bad); else n_pass++;
    n_total++; if ({g0, g1} !== {32'd5, 32'd5}) $display("FAIL b2b_grants got=%0d/%0d exp=5/5", g0, g1); else n_pass++;
    n_total++; if (cnt !== 16'(exp_cnt)) $display("FAIL b2b_cnt got=%0d exp=%0d", cnt, exp_cnt); else n_pass++;
    n_total++; if (s_cnt !== 2'd3) $display("FAIL b2b_sat_cnt got=%0d exp=3", s_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    l0_v = 1'b1; l0_addr = 32'h10; l0_we = 1'b0; l0_rd = 5'd11;
    l1_v = 1'b1; l1_addr = 32'h20; l1_we = 1'b0; l1_rd = 5'd12;
    @(negedge clk);
    n_total++; if (l0_rdy !== 1'b1) $display("FAIL rstmid_l0_grant got=%0h exp=1", l0_rdy); else n_pass++;
    tick();
    l0_v = 1'b0;
    #1;
    n_total++; if ({l1_rdy, l0_rv} !== 2'b11) $display("FAIL rstmid_serve1 got=%b exp=11", {l1_rdy, l0_rv}); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if ({l0_rdy, l1_rdy, mem_en, l0_rv, l1_rv} !== 5'b0) $display("FAIL rstmid_quiet got=%b exp=00000", {l0_rdy, l1_rdy, mem_en, l0_rv, l1_rv}); else n_pass++;
    n_total++; if ({cnt, s_cnt} !== 18'd0) $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", cnt, s_cnt); else n_pass++;
    rst_n = 1'b1; exp_cnt = 0;
    l0_v = 1'b1;
    #1;
    n_total++; if ({l0_rdy, l1_rdy} !== 2'b10) $display("FAIL rstmid_from_idle got=%b exp=10", {l0_rdy, l1_rdy}); else n_pass++;
    tick();
    l0_v = 1'b0; exp_cnt++;
    @(negedge clk);
    n_total++; if ({l1_rdy, cnt} !== {1'b1, 16'(exp_cnt)}) $display("FAIL rstmid_after got=%b/%0d exp=1/%0d", l1_rdy, cnt, exp_cnt); else n_pass++;
    tick();
    l1_v = 1'b0;
    tick();
  endtask

  // Random requests live in words 32..47, plus occasional misaligned / out-of-range ones.
  task automatic gen_req(output logic [31:0] a, output logic [31:0] wd, output logic we, output logic [4:0] rd);
    int unsigned r = $urandom_range(0, 15);
    int unsigned w = $urandom_range(32, 47);
    if (r == 0)      a = 32'(w * 4 + $urandom_range(1, 3));
    else if (r == 1) a = 32'h1000 + 32'(w * 4);
    else             a = 32'(w * 4);
    wd = $urandom;
    we = $urandom_range(0, 1) == 1;
    rd = 5'($urandom_range(0, 31));
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [int];
    bit owed = 0, pend = 0, plane = 0, pf = 0;
    logic [31:0] pdata = '0;
    logic [4:0]  prd = '0;
    int mcnt = 0;
    int errs = 0;
    rst_n = 1'b0; l0_v = 1'b0; l1_v = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    for (int c = 0; c < 400; c++) begin
      bit e0, e1, iss, lane, flt, we, e_en, ev0, ev1;
      logic [31:0] a, wd;
      logic [4:0]  rd;
      int idx;
      @(negedge clk);
      e0 = !flush && l0_v && !owed;
      e1 = !flush && l1_v && (owed || !l0_v);
      if ({l0_rdy, l1_rdy} !== {e0, e1}) begin errs++; $display("FAIL rand_ready c=%0d got=%b exp=%b%b", c, {l0_rdy, l1_rdy}, e0, e1); end
      iss = e0 || e1; lane = e1;
      a = lane ? l1_addr : l0_addr; wd = lane ? l1_wd : l0_wd;
      we = lane ? l1_we : l0_we;    rd = lane ? l1_rd : l0_rd;
      flt = (a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
      idx = int'(a[11:2]);
      e_en = iss && !flt;
      if (mem_en !== e_en) begin errs++; $display("FAIL rand_mem_en c=%0d got=%b exp=%b", c, mem_en, e_en); end
      else if (e_en && ({mem_we, mem_addr} !== {we, 10'(idx)} || (we && mem_wdata !== wd))) begin
        errs++; $display("FAIL rand_mem_bus c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, mem_we, mem_addr, mem_wdata, we, idx, wd);
      end
      ev0 = pend && !plane && !flush;
      ev1 = pend && plane && !flush;
      if ({l0_rv, l1_rv} !== {ev0, ev1}) begin errs++; $display("FAIL rand_rsp_valid c=%0d got=%b exp=%b%b", c, {l0_rv, l1_rv}, ev0, ev1); end
      if (ev0 && {l0_rdat, l0_rrd, l0_rf} !== {pdata, prd, pf}) begin errs++; $display("FAIL rand_l0_rsp c=%0d got=%h/%0d/%b exp=%h/%0d/%b", c, l0_rdat, l0_rrd, l0_rf, pdata, prd, pf); end
      if (ev1 && {l1_rdat, l1_rrd, l1_rf} !== {pdata, prd, pf}) begin errs++; $display("FAIL rand_l1_rsp c=%0d got=%h/%0d/%b exp=%h/%0d/%b", c, l1_rdat, l1_rrd, l1_rf, pdata, prd, pf); end
      if (cnt !== 16'(mcnt) || s_cnt !== 2'((mcnt > 3) ? 3 : mcnt)) begin errs++; $display("FAIL rand_cnt c=%0d got=%0d/%0d exp=%0d", c, cnt, s_cnt, mcnt); end
      pend = iss; plane = lane; prd = rd; pf = flt;
      pdata = (flt || we) ? 32'd0 : (ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx));
      if (e_en && we) ref_mem[idx] = wd;
      if (!flush && !owed && l0_v && l1_v) begin owed = 1; mcnt++; end
      else owed = 0;
      tick();
      if (e0 || !l0_v) begin
        l0_v = $urandom_range(0, 9) < 7;
        if (l0_v) gen_req(l0_addr, l0_wd, l0_we, l0_rd);
      end
      if (e1 || !l1_v) begin
        l1_v = $urandom_range(0, 9) < 7;
        if (l1_v) gen_req(l1_addr, l1_wd, l1_we, l1_rd);
      end
      flush = $urandom_range(0, 15) == 0;
    end
    l0_v = 1'b0; l1_v = 1'b0; flush = 1'b0;
    n_total++; if (errs !== 0) $display("FAIL rand_model got=%0d exp=0 mismatching cycles", errs); else n_pass++;
    n_total++; if (mcnt < 10) $display("FAIL rand_coverage got=%0d exp>=10 conflicts", mcnt); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_conflict();
    test_fault();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
